mem_bus_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction-fetch port (IF, beside pc_reg/if_id) and the data-access port (MEM stage).
- Sequences each transfer with a req/ack handshake on the shared bus.
- Drives per-port stall requests into ctrl so the pipeline freezes while a port waits.
- Data port has priority. A starvation counter guarantees fetch forward progress. A pipeline flush cancels an in-flight fetch without corrupting the bus.

---
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the fetch and data ports
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        stallreq_from_if,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_from_mem,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);
  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, IF_KILL} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d, if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [3:0] bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic if_elig, mem_elig, forced;
  // a request just acknowledged is not re-granted while its req is still high
  assign if_elig = if_req_i & ~if_ack_q;
  assign mem_elig = mem_req_i & ~mem_ack_q;
  assign forced = if_elig & (starve_q == LIMIT) & ~flush_i;
  assign stallreq_from_if = if_req_i & ~if_ack_q;
  assign stallreq_from_mem = mem_req_i & ~mem_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign if_ack_o = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o = mem_ack_q;
  assign bus_req_o = bus_req_q;
  assign bus_we_o = bus_we_q;
  assign bus_sel_o = bus_sel_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  // arbitration and transfer sequencing; data wins unless the fetch has starved
  always_comb begin
    state_d = state_q;
    starve_d = starve_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_sel_d = bus_sel_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d = 1'b0;
    mem_ack_d = 1'b0;
    case (state_q)
      IDLE:
        if (mem_elig && !forced) begin
          state_d = BUS_MEM;
          bus_req_d = 1'b1;
          bus_we_d = mem_we_i;
          bus_sel_d = mem_sel_i;
          bus_addr_d = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_elig && !flush_i) begin
          state_d = BUS_IF;
          bus_req_d = 1'b1;
          bus_we_d = 1'b0;
          bus_sel_d = 4'b1111;
          bus_addr_d = if_addr_i;
          bus_wdata_d = '0;
        end
      BUS_MEM:
        if (bus_ack_i) begin
          state_d = IDLE;
          bus_req_d = 1'b0;
          mem_ack_d = 1'b1;
          mem_rdata_d = bus_rdata_i;
          starve_d = !if_req_i ? '0 : (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
        end
      BUS_IF:
        if (flush_i) begin
          state_d = bus_ack_i ? IDLE : IF_KILL;
          bus_req_d = ~bus_ack_i;
          starve_d = '0;
        end else if (bus_ack_i) begin
          state_d = IDLE;
          bus_req_d = 1'b0;
          if_ack_d = 1'b1;
          if_rdata_d = bus_rdata_i;
          starve_d = '0;
        end
      IF_KILL:
        if (bus_ack_i) begin
          state_d = IDLE;
          bus_req_d = 1'b0;
          starve_d = '0;
        end
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      starve_q <= '0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_sel_q <= '0;
      bus_addr_q <= '0;
      bus_wdata_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
      if_ack_q <= 1'b0;
      mem_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_sel_q <= bus_sel_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q <= if_ack_d;
      mem_ack_q <= mem_ack_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random checks of the bus arbiter against a transfer-level model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush_i, if_req_i, if_ack_o, stallreq_from_if;
  logic mem_req_i, mem_we_i, mem_ack_o, stallreq_from_mem;
  logic bus_req_o, bus_we_o, bus_ack_i;
  logic [3:0] mem_sel_i, bus_sel_o;
  logic [31:0] if_addr_i, if_rdata_o, mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  int checks = 0, errors = 0;
  // reference model: the single outstanding transfer and the port-visible results
  bit m_busy, m_fetch, m_killed, m_we, m_if_ack, m_mem_ack;
  logic [3:0] m_sel;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;
  int m_starve;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .stallreq_from_if(stallreq_from_if),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .stallreq_from_mem(stallreq_from_mem),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model();
    bit if_el, mem_el, forced;
    if (rst) begin
      {m_busy, m_fetch, m_killed, m_we, m_if_ack, m_mem_ack} = '0;
      m_sel = '0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0; m_starve = 0;
      return;
    end
    if_el = if_req_i && !m_if_ack;
    mem_el = mem_req_i && !m_mem_ack;
    forced = if_el && m_starve == 4 && !flush_i;
    m_if_ack = 0;
    m_mem_ack = 0;
    if (!m_busy) begin
      if (mem_el && !forced) begin
        m_busy = 1; m_fetch = 0; m_killed = 0;
        m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
      end else if (if_el && !flush_i) begin
        m_busy = 1; m_fetch = 1; m_killed = 0;
        m_we = 0; m_sel = 4'hF; m_addr = if_addr_i; m_wdata = 0;
      end
    end else if (bus_ack_i) begin
      m_busy = 0;
      if (!m_fetch) begin
        m_mem_ack = 1; m_mem_rd = bus_rdata_i;
        m_starve = if_req_i ? ((m_starve + 1 > 4) ? 4 : m_starve + 1) : 0;
      end else begin
        m_starve = 0;
        if (!m_killed && !flush_i) begin
          m_if_ack = 1; m_if_rd = bus_rdata_i;
        end
      end
    end else if (m_fetch && flush_i) m_killed = 1;
  endtask

  task automatic check_all();
    chk("bus_req", bus_req_o, m_busy);
    chk("bus_we", bus_we_o, m_we);
    chk("bus_sel", bus_sel_o, m_sel);
    chk("bus_addr", bus_addr_o, m_addr);
    chk("bus_wdata", bus_wdata_o, m_wdata);
    chk("if_ack", if_ack_o, m_if_ack);
    chk("mem_ack", mem_ack_o, m_mem_ack);
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("mem_rdata", mem_rdata_o, m_mem_rd);
    chk("stall_if", stallreq_from_if, if_req_i & ~m_if_ack);
    chk("stall_mem", stallreq_from_mem, mem_req_i & ~m_mem_ack);
  endtask

  task automatic tick();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int n, guard;
    logic [31:0] saved;
    rst = 1; flush_i = 0; if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0;
    mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    tick(); tick();
    chk("reset_bus_req", bus_req_o, 0);
    rst = 0;
    // single fetch with a zero-wait slave
    if_req_i = 1; if_addr_i = 32'h40; bus_rdata_i = 32'h3401_0020;
    #1 chk("t1_stall_c0", stallreq_from_if, 1);
    tick();
    chk("t1_req_c1", bus_req_o, 1); chk("t1_addr_c1", bus_addr_o, 32'h40);
    chk("t1_sel_c1", bus_sel_o, 4'hF); chk("t1_we_c1", bus_we_o, 0);
    chk("t1_stall_c1", stallreq_from_if, 1);
    bus_ack_i = 1; tick();
    chk("t1_ack_c2", if_ack_o, 1); chk("t1_rdata_c2", if_rdata_o, 32'h3401_0020);
    chk("t1_stall_c2", stallreq_from_if, 0);
    if_req_i = 0; bus_ack_i = 0; tick();
    // simultaneous requests: data first, fetch in the idle cycle after mem_ack
    if_req_i = 1; if_addr_i = 32'h80; mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011; bus_rdata_i = 32'h1111_2222;
    tick();
    chk("t2_we", bus_we_o, 1); chk("t2_sel", bus_sel_o, 4'b0011); chk("t2_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    bus_ack_i = 1; tick();
    chk("t2_mem_ack", mem_ack_o, 1);
    bus_ack_i = 0; tick();
    chk("t2_fetch_addr", bus_addr_o, 32'h80); chk("t2_fetch_we", bus_we_o, 0);
    mem_req_i = 0; bus_ack_i = 1; bus_rdata_i = 32'h3333_4444; tick();
    chk("t2_if_ack", if_ack_o, 1); chk("t2_no_double", mem_ack_o, 0);
    if_req_i = 0; bus_ack_i = 0; tick();
    // starvation: idle cycles blocked by flush let data keep winning until the limit
    if_req_i = 1; if_addr_i = 32'h700; mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h704;
    mem_sel_i = 4'hF; bus_rdata_i = 32'h5555_6666;
    n = 0; guard = 0;
    while (!(m_busy && m_fetch) && guard < 100) begin
      bus_ack_i = m_busy;
      flush_i = (n < 4) || m_mem_ack;
      tick();
      if (m_mem_ack) n++;
      guard++;
    end
    chk("t3_guard", guard < 100, 1);
    chk("t3_data_count", n, 4);
    chk("t3_fetch_addr", bus_addr_o, 32'h700);
    flush_i = 0; mem_req_i = 0; bus_ack_i = 1; bus_rdata_i = 32'h7777_8888; tick();
    chk("t3_if_ack", if_ack_o, 1);
    if_req_i = 0; bus_ack_i = 0; tick();
    // flush while a fetch waits on the slave
    saved = 32'h7777_8888;
    if_req_i = 1; if_addr_i = 32'h300; bus_rdata_i = 32'hBAD0_BAD0; tick();
    tick();
    flush_i = 1; tick();
    chk("t4_req_held", bus_req_o, 1);
    flush_i = 0; if_addr_i = 32'h200; bus_ack_i = 1; tick();
    chk("t4_no_ack", if_ack_o, 0); chk("t4_rdata_kept", if_rdata_o, saved); chk("t4_req_drop", bus_req_o, 0);
    bus_ack_i = 0; tick();
    chk("t4_refetch_addr", bus_addr_o, 32'h200);
    bus_ack_i = 1; bus_rdata_i = 32'h0000_0200; tick();
    chk("t4_refetch_ack", if_ack_o, 1); chk("t4_refetch_data", if_rdata_o, 32'h0000_0200);
    if_req_i = 0; bus_ack_i = 0; tick();
    // reset in the middle of a data transfer
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h500; tick();
    chk("t5_req", bus_req_o, 1);
    rst = 1; tick();
    chk("t5_rst_req", bus_req_o, 0); chk("t5_rst_addr", bus_addr_o, 0);
    rst = 0; mem_req_i = 0; bus_ack_i = 1; tick();
    chk("t5_late_ack", mem_ack_o, 0);
    mem_req_i = 1; bus_ack_i = 0; tick();
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_0500; tick();
    chk("t5_after_ack", mem_ack_o, 1); chk("t5_after_data", mem_rdata_o, 32'hCAFE_0500);
    mem_req_i = 0; bus_ack_i = 0; tick();
    // wait-state slave on a data read
    mem_req_i = 1; mem_addr_i = 32'h600; mem_sel_i = 4'b0101; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_addr_stable", bus_addr_o, 32'h600); chk("t6_sel_stable", bus_sel_o, 4'b0101);
      chk("t6_stall", stallreq_from_mem, 1);
    end
    bus_ack_i = 1; bus_rdata_i = 32'h0606_0606; tick();
    chk("t6_ack", mem_ack_o, 1);
    bus_ack_i = 0; tick();
    chk("t6_ack_once", mem_ack_o, 0);
    mem_req_i = 0; bus_ack_i = 1; tick();
    bus_ack_i = 0; tick();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (if_req_i && m_if_ack) if_req_i = 0;
      else if (!if_req_i && $urandom_range(2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (mem_req_i && m_mem_ack) mem_req_i = 0;
      else if (!mem_req_i && $urandom_range(2) == 0) begin
        mem_req_i = 1; mem_we_i = $urandom_range(1); mem_sel_i = 4'($urandom);
        mem_addr_i = $urandom; mem_wdata_i = $urandom;
      end
      flush_i = $urandom_range(7) == 0;
      bus_ack_i = $urandom_range(1);
      bus_rdata_i = $urandom;
      rst = $urandom_range(96) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
